rv_mc_ctrl: RTL and testbench

- Multi-cycle control unit for the RV32I core; the successor to the single-cycle combinational decoder.
- Sequences each instruction through a state machine: FETCH, DECODE, then per-class execute, memory and writeback states.
- Adds a memory ready handshake, full branch-condition evaluation, store width control, illegal-instruction trap, and a retired-instruction counter.
- Sits between the instruction register / ALU flags and the shared datapath muxes, register file and memory port.

---
 rtl/rv_defs.sv | 99 +++++++++
 rtl/rv_alu_dec.sv | 64 ++++++
 rtl/rv_mc_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_rv_mc_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_defs.sv
// Shared RV32I control/datapath definitions: opcodes, funct3 codes, ALU
// operation codes, datapath mux selects and the multi-cycle FSM encoding.
package rv_defs;

   localparam int unsigned ALU_W   = 4;
   localparam int unsigned STATE_W = 4;

   // Major opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // ALU operation codes
   localparam logic [ALU_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [ALU_W-1:0] ALU_SUB  = 4'd1;
   localparam logic [ALU_W-1:0] ALU_XOR  = 4'd2;
   localparam logic [ALU_W-1:0] ALU_OR   = 4'd3;
   localparam logic [ALU_W-1:0] ALU_AND  = 4'd4;
   localparam logic [ALU_W-1:0] ALU_SLL  = 4'd5;
   localparam logic [ALU_W-1:0] ALU_SRL  = 4'd6;
   localparam logic [ALU_W-1:0] ALU_SRA  = 4'd7;
   localparam logic [ALU_W-1:0] ALU_SLT  = 4'd8;
   localparam logic [ALU_W-1:0] ALU_SLTU = 4'd9;

   // Arithmetic funct3 / funct7
   localparam logic [2:0] F3_ADD  = 3'd0;
   localparam logic [2:0] F3_SLL  = 3'd1;
   localparam logic [2:0] F3_SLT  = 3'd2;
   localparam logic [2:0] F3_SLTU = 3'd3;
   localparam logic [2:0] F3_XOR  = 3'd4;
   localparam logic [2:0] F3_SR   = 3'd5;
   localparam logic [2:0] F3_OR   = 3'd6;
   localparam logic [2:0] F3_AND  = 3'd7;
   localparam logic [6:0] F7_BASE = 7'h00;
   localparam logic [6:0] F7_ALT  = 7'h20;

   // Branch funct3
   localparam logic [2:0] F3_BEQ  = 3'd0;
   localparam logic [2:0] F3_BNE  = 3'd1;
   localparam logic [2:0] F3_BLT  = 3'd4;
   localparam logic [2:0] F3_BGE  = 3'd5;
   localparam logic [2:0] F3_BLTU = 3'd6;
   localparam logic [2:0] F3_BGEU = 3'd7;

   // Load / store widths
   localparam logic [2:0] LOAD_LB  = 3'd0;
   localparam logic [2:0] LOAD_LH  = 3'd1;
   localparam logic [2:0] LOAD_LW  = 3'd2;
   localparam logic [2:0] LOAD_LBU = 3'd4;
   localparam logic [2:0] LOAD_LHU = 3'd5;
   localparam logic [1:0] STORE_SB = 2'd0;
   localparam logic [1:0] STORE_SH = 2'd1;
   localparam logic [1:0] STORE_SW = 2'd2;

   // Immediate format selects
   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   // Result selects
   localparam logic [1:0] RES_ALUOUT = 2'd0;
   localparam logic [1:0] RES_MEM    = 2'd1;
   localparam logic [1:0] RES_ALU    = 2'd2;

   // ALU operand selects
   localparam logic [1:0] SRC_A_PC    = 2'd0;
   localparam logic [1:0] SRC_A_OLDPC = 2'd1;
   localparam logic [1:0] SRC_A_RS1   = 2'd2;
   localparam logic [1:0] SRC_B_RS2   = 2'd0;
   localparam logic [1:0] SRC_B_IMM   = 2'd1;
   localparam logic [1:0] SRC_B_FOUR  = 2'd2;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEM_ADR = 4'd2,
      S_MEM_RD  = 4'd3,
      S_MEM_WB  = 4'd4,
      S_MEM_WR  = 4'd5,
      S_EXEC_R  = 4'd6,
      S_EXEC_I  = 4'd7,
      S_ALU_WB  = 4'd8,
      S_JAL     = 4'd9,
      S_JALR    = 4'd10,
      S_BRANCH  = 4'd11,
      S_LUI     = 4'd12,
      S_AUIPC   = 4'd13,
      S_HALT    = 4'd14
   } state_e;

endpackage

// File: rtl/rv_alu_dec.sv
// ALU operation decoder for R-type and I-type arithmetic.
//   funct3/funct7 : instruction fields
//   is_r          : 1 = register-register form (SUB and funct7 checks apply)
//   alu_ctrl      : ALU operation code
//   illegal       : funct7 value not defined for this operation
module rv_alu_dec
   import rv_defs::*;
(
   input  logic [2:0]       funct3,
   input  logic [6:0]       funct7,
   input  logic             is_r,
   output logic [ALU_W-1:0] alu_ctrl,
   output logic             illegal
);

   logic f7_base;
   logic f7_alt;

   assign f7_base = (funct7 == F7_BASE);
   assign f7_alt  = (funct7 == F7_ALT);

   always_comb begin
      alu_ctrl = ALU_ADD;
      illegal  = 1'b0;
      case (funct3)
         F3_ADD: begin
            // ADDI takes a full 12-bit immediate, so funct7 only matters for R-type
            if (is_r) begin
               if (f7_alt)        alu_ctrl = ALU_SUB;
               else if (!f7_base) illegal  = 1'b1;
            end
         end
         F3_SLL: begin
            alu_ctrl = ALU_SLL;
            illegal  = !f7_base;
         end
         F3_SLT: begin
            alu_ctrl = ALU_SLT;
            illegal  = is_r && !f7_base;
         end
         F3_SLTU: begin
            alu_ctrl = ALU_SLTU;
            illegal  = is_r && !f7_base;
         end
         F3_XOR: begin
            alu_ctrl = ALU_XOR;
            illegal  = is_r && !f7_base;
         end
         F3_SR: begin
            alu_ctrl = f7_alt ? ALU_SRA : ALU_SRL;
            illegal  = !f7_alt && !f7_base;
         end
         F3_OR: begin
            alu_ctrl = ALU_OR;
            illegal  = is_r && !f7_base;
         end
         default: begin
            alu_ctrl = ALU_AND;
            illegal  = is_r && !f7_base;
         end
      endcase
   end

endmodule

// File: rtl/rv_mc_ctrl.sv
// Multi-cycle RV32I control unit. Sequences each instruction through
// FETCH/DECODE and per-class execute, memory and writeback states.
//   clk, rst      : clock, async active-high reset
//   instr         : instruction register, valid from DECODE onward
//   zero/lt/ltu   : ALU comparison flags for branches
//   mem_ready     : memory access completes this cycle
//   pc_we..store_ctrl : datapath enables and mux selects
//   illegal       : sticky undefined-instruction flag
//   halted        : FSM parked in HALT
//   instret       : retired-instruction counter (wraps)
module rv_mc_ctrl
   import rv_defs::*;
#(
   parameter bit          MEM_WAIT  = 1'b1,
   parameter int unsigned CNT_W     = 32,
   parameter bit          TRAP_HALT = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             zero,
   input  logic             lt,
   input  logic             ltu,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             ir_we,
   output logic             adr_src,
   output logic             mem_re,
   output logic             mem_we,
   output logic [1:0]       alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [3:0]       alu_ctrl,
   output logic [1:0]       res_src,
   output logic [2:0]       imm_src,
   output logic             reg_we,
   output logic [2:0]       load_ctrl,
   output logic [1:0]       store_ctrl,
   output logic             illegal,
   output logic             halted,
   output logic [CNT_W-1:0] instret
);

   state_e           state_q, state_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] instret_q, instret_d;

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;
   logic             mem_ok;
   logic             trap;
   logic             retire;
   logic [3:0]       dec_alu_ctrl;
   logic             dec_illegal;
   logic             unused_fields;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   // Register indices are consumed by the datapath, not here
   assign unused_fields = ^{instr[24:15], instr[11:7]};

   // With a single-cycle memory every access completes immediately
   assign mem_ok = mem_ready || !MEM_WAIT;

   rv_alu_dec u_alu_dec (
      .funct3   (funct3),
      .funct7   (funct7),
      .is_r     (state_q == S_EXEC_R),
      .alu_ctrl (dec_alu_ctrl),
      .illegal  (dec_illegal)
   );

   // State, sticky trap flag and retire counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         instret_q <= instret_d;
      end
   end

   // Next state and datapath controls; reset forces every control to idle
   always_comb begin
      state_d    = state_q;
      illegal_d  = illegal_q;
      trap       = 1'b0;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      adr_src    = 1'b0;
      mem_re     = 1'b0;
      mem_we     = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      alu_ctrl   = ALU_ADD;
      res_src    = RES_ALUOUT;
      imm_src    = IMM_I;
      reg_we     = 1'b0;
      load_ctrl  = 3'd0;
      store_ctrl = STORE_SB;
      halted     = 1'b0;

      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               mem_re    = 1'b1;
               alu_src_b = SRC_B_FOUR;
               if (mem_ok) begin
                  ir_we   = 1'b1;
                  pc_we   = 1'b1;
                  state_d = S_DECODE;
               end
            end
            S_DECODE: begin
               // Precompute the jump/branch target into the ALU result register
               alu_src_a = SRC_A_OLDPC;
               alu_src_b = SRC_B_IMM;
               imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
               case (opcode)
                  OP_LOAD: begin
                     if (funct3 == LOAD_LB || funct3 == LOAD_LH || funct3 == LOAD_LW ||
                         funct3 == LOAD_LBU || funct3 == LOAD_LHU)
                        state_d = S_MEM_ADR;
                     else
                        trap = 1'b1;
                  end
                  OP_STORE: begin
                     if (funct3 <= {1'b0, STORE_SW}) state_d = S_MEM_ADR;
                     else                            trap    = 1'b1;
                  end
                  OP_OP:     state_d = S_EXEC_R;
                  OP_IMM:    state_d = S_EXEC_I;
                  OP_JAL:    state_d = S_JAL;
                  OP_JALR: begin
                     if (funct3 == 3'd0) state_d = S_JALR;
                     else                trap    = 1'b1;
                  end
                  OP_BRANCH: state_d = S_BRANCH;
                  OP_LUI:    state_d = S_LUI;
                  OP_AUIPC:  state_d = S_AUIPC;
                  default:   trap    = 1'b1;
               endcase
            end
            S_MEM_ADR: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               if (opcode == OP_STORE) begin
                  imm_src = IMM_S;
                  state_d = S_MEM_WR;
               end else begin
                  load_ctrl = funct3;
                  state_d   = S_MEM_RD;
               end
            end
            S_MEM_RD: begin
               adr_src   = 1'b1;
               mem_re    = 1'b1;
               load_ctrl = funct3;
               if (mem_ok) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
               res_src   = RES_MEM;
               reg_we    = 1'b1;
               load_ctrl = funct3;
               state_d   = S_FETCH;
            end
            S_MEM_WR: begin
               adr_src    = 1'b1;
               mem_we     = 1'b1;
               store_ctrl = funct3[1:0];
               if (mem_ok) state_d = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = (state_q == S_EXEC_R) ? SRC_B_RS2 : SRC_B_IMM;
               alu_ctrl  = dec_alu_ctrl;
               if (dec_illegal) trap    = 1'b1;
               else             state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
               res_src = RES_ALUOUT;
               reg_we  = 1'b1;
               state_d = S_FETCH;
            end
            S_JAL: begin
               // PC takes the precomputed target while the ALU forms the link value
               alu_src_a = SRC_A_OLDPC;
               alu_src_b = SRC_B_FOUR;
               res_src   = RES_ALUOUT;
               pc_we     = 1'b1;
               state_d   = S_ALU_WB;
            end
            S_JALR: begin
               // rs1+imm lands in the ALU result register; JAL then jumps there
               // (datapath clears bit 0) and writes the link value
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               state_d   = S_JAL;
            end
            S_BRANCH: begin
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_RS2;
               alu_ctrl  = ALU_SUB;
               imm_src   = IMM_B;
               res_src   = RES_ALUOUT;
               state_d   = S_FETCH;
               case (funct3)
                  F3_BEQ:  pc_we = zero;
                  F3_BNE:  pc_we = !zero;
                  F3_BLT:  pc_we = lt;
                  F3_BGE:  pc_we = !lt;
                  F3_BLTU: pc_we = ltu;
                  F3_BGEU: pc_we = !ltu;
                  default: trap  = 1'b1;
               endcase
            end
            S_LUI: begin
               // Datapath reads x0 on port A for LUI, so the sum is the U immediate
               alu_src_a = SRC_A_RS1;
               alu_src_b = SRC_B_IMM;
               imm_src   = IMM_U;
               state_d   = S_ALU_WB;
            end
            S_AUIPC: begin
               alu_src_a = SRC_A_OLDPC;
               alu_src_b = SRC_B_IMM;
               imm_src   = IMM_U;
               state_d   = S_ALU_WB;
            end
            S_HALT: begin
               halted = 1'b1;
            end
            default: begin
               state_d = S_FETCH;
            end
         endcase

         // Undefined instruction: park, or skip it as a counted NOP
         if (trap) begin
            illegal_d = 1'b1;
            if (TRAP_HALT) state_d = S_HALT;
            else           state_d = S_FETCH;
         end
      end

      retire    = (state_d == S_FETCH) && (state_q != S_FETCH);
      instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
   end

   assign illegal = illegal_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_rv_mc_ctrl.sv
// Directed bench for rv_mc_ctrl with a 4-bit retire counter.
module tb_rv_mc_ctrl;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        zero, lt, ltu, mem_ready;
   logic        pc_we, ir_we, adr_src, mem_re, mem_we;
   logic [1:0]  alu_src_a, alu_src_b, res_src, store_ctrl;
   logic [3:0]  alu_ctrl;
   logic [2:0]  imm_src, load_ctrl;
   logic        reg_we, illegal, halted;
   logic [3:0]  instret;

   int n_chk  = 0;
   int n_fail = 0;

   rv_mc_ctrl #(.MEM_WAIT(1'b1), .CNT_W(4), .TRAP_HALT(1'b1)) dut (
      .clk(clk), .rst(rst), .instr(instr), .zero(zero), .lt(lt), .ltu(ltu),
      .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .adr_src(adr_src),
      .mem_re(mem_re), .mem_we(mem_we), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .res_src(res_src),
      .imm_src(imm_src), .reg_we(reg_we), .load_ctrl(load_ctrl),
      .store_ctrl(store_ctrl), .illegal(illegal), .halted(halted),
      .instret(instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [25:0] obs;
   assign obs = {pc_we, ir_we, adr_src, mem_re, mem_we, alu_src_a, alu_src_b,
                 alu_ctrl, res_src, imm_src, reg_we, load_ctrl, store_ctrl,
                 illegal, halted};

   function automatic logic [25:0] ev(
      input logic pcw, input logic irw, input logic adr, input logic re,
      input logic we, input logic [1:0] a, input logic [1:0] b,
      input logic [3:0] alu, input logic [1:0] res, input logic [2:0] imm,
      input logic rw, input logic [2:0] ld, input logic [1:0] st,
      input logic ill, input logic hlt);
      return {pcw, irw, adr, re, we, a, b, alu, res, imm, rw, ld, st, ill, hlt};
   endfunction

   localparam logic [25:0] V_IDLE  = ev(0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0);
   localparam logic [25:0] V_FETCH = ev(1,1,0,1,0, 0,2,0,0,0, 0,0,0,0,0);
   localparam logic [25:0] V_FSTAL = ev(0,0,0,1,0, 0,2,0,0,0, 0,0,0,0,0);
   localparam logic [25:0] V_DEC   = ev(0,0,0,0,0, 1,1,0,0,2, 0,0,0,0,0);
   localparam logic [25:0] V_WB    = ev(0,0,0,0,0, 0,0,0,0,0, 1,0,0,0,0);
   localparam logic [25:0] V_LWADR = ev(0,0,0,0,0, 2,1,0,0,0, 0,2,0,0,0);
   localparam logic [25:0] V_LWRD  = ev(0,0,1,1,0, 0,0,0,0,0, 0,2,0,0,0);
   localparam logic [25:0] V_LWWB  = ev(0,0,0,0,0, 0,0,0,1,0, 1,2,0,0,0);
   localparam logic [25:0] V_SHADR = ev(0,0,0,0,0, 2,1,0,0,1, 0,0,0,0,0);
   localparam logic [25:0] V_SHWR  = ev(0,0,1,0,1, 0,0,0,0,0, 0,0,1,0,0);
   localparam logic [25:0] V_BRT   = ev(1,0,0,0,0, 2,0,1,0,2, 0,0,0,0,0);
   localparam logic [25:0] V_BRN   = ev(0,0,0,0,0, 2,0,1,0,2, 0,0,0,0,0);
   localparam logic [25:0] V_JDEC  = ev(0,0,0,0,0, 1,1,0,0,4, 0,0,0,0,0);
   localparam logic [25:0] V_JAL   = ev(1,0,0,0,0, 1,2,0,0,0, 0,0,0,0,0);
   localparam logic [25:0] V_HALT  = ev(0,0,0,0,0, 0,0,0,0,0, 0,0,0,1,1);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Check controls for the current state, then advance one clock
   task automatic cyc(input string tag, input logic [25:0] e);
      #1;
      check(tag, 32'(obs), 32'(e));
      @(posedge clk);
      #1;
   endtask

   task automatic run_alu(input string tag, input logic [31:0] ins,
                          input bit is_r, input logic [3:0] alu);
      instr = ins;
      cyc({tag, "_fetch"}, V_FETCH);
      cyc({tag, "_decode"}, V_DEC);
      cyc({tag, "_exec"}, is_r ? ev(0,0,0,0,0, 2,0,alu,0,0, 0,0,0,0,0)
                               : ev(0,0,0,0,0, 2,1,alu,0,0, 0,0,0,0,0));
      cyc({tag, "_wb"}, V_WB);
   endtask

   initial begin
      rst = 1'b1; instr = 32'h0; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
      mem_ready = 1'b1;
      @(posedge clk); #1;
      check("rst_ctl", 32'(obs), 32'(V_IDLE));
      check("rst_instret", 32'(instret), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // add x3,x1,x2
      run_alu("add", 32'h002081B3, 1'b1, 4'd0);
      check("add_instret", 32'(instret), 32'd1);

      // lw x5,4(x1) with three wait cycles in MEM_RD
      instr = 32'h0040A283;
      cyc("lw_fetch", V_FETCH);
      cyc("lw_decode", V_DEC);
      cyc("lw_adr", V_LWADR);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) cyc("lw_rd_wait", V_LWRD);
      mem_ready = 1'b1;
      cyc("lw_rd_done", V_LWRD);
      cyc("lw_wb", V_LWWB);
      check("lw_instret", 32'(instret), 32'd2);

      // beq x0,x0,8 taken then not taken
      instr = 32'h00000463;
      zero = 1'b1;
      cyc("beqt_fetch", V_FETCH);
      cyc("beqt_decode", V_DEC);
      cyc("beqt_branch", V_BRT);
      check("beqt_instret", 32'(instret), 32'd3);
      zero = 1'b0;
      cyc("beqn_fetch", V_FETCH);
      cyc("beqn_decode", V_DEC);
      cyc("beqn_branch", V_BRN);
      check("beqn_instret", 32'(instret), 32'd4);

      // sh x2,6(x1) with a fetch stall and two write wait cycles
      instr = 32'h00209323;
      mem_ready = 1'b0;
      cyc("sh_fetch_stall", V_FSTAL);
      mem_ready = 1'b1;
      cyc("sh_fetch", V_FETCH);
      cyc("sh_decode", V_DEC);
      cyc("sh_adr", V_SHADR);
      mem_ready = 1'b0;
      for (int i = 0; i < 2; i++) cyc("sh_wr_wait", V_SHWR);
      mem_ready = 1'b1;
      cyc("sh_wr_done", V_SHWR);
      check("sh_instret", 32'(instret), 32'd5);

      run_alu("sub", 32'h40208133, 1'b1, 4'd1);
      run_alu("sra", 32'h4020D1B3, 1'b1, 4'd7);
      run_alu("srai", 32'h4010D093, 1'b0, 4'd7);
      check("shift_instret", 32'(instret), 32'd8);

      // jal x1,8
      instr = 32'h008000EF;
      cyc("jal_fetch", V_FETCH);
      cyc("jal_decode", V_JDEC);
      cyc("jal_jump", V_JAL);
      cyc("jal_wb", V_WB);
      check("jal_instret", 32'(instret), 32'd9);

      // counter wrap at 2^4
      for (int i = 0; i < 6; i++) run_alu("addi", 32'h00108093, 1'b0, 4'd0);
      check("instret_max", 32'(instret), 32'd15);
      run_alu("addi_wrap", 32'h00108093, 1'b0, 4'd0);
      check("instret_wrap", 32'(instret), 32'd0);
      run_alu("addi_post", 32'h00108093, 1'b0, 4'd0);
      check("instret_post", 32'(instret), 32'd1);

      // undefined opcode traps into HALT
      instr = 32'hFFFFFFFF;
      cyc("ill_fetch", V_FETCH);
      cyc("ill_decode", V_DEC);
      for (int i = 0; i < 3; i++) cyc("ill_halt", V_HALT);
      check("ill_instret", 32'(instret), 32'd1);

      // reset pulse clears the trap and counter
      rst = 1'b1;
      #1;
      check("rst2_ctl", 32'(obs), 32'(V_IDLE));
      check("rst2_instret", 32'(instret), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // undefined funct7 in R-type traps from EXEC_R
      instr = 32'h022081B3;
      cyc("badf7_fetch", V_FETCH);
      cyc("badf7_decode", V_DEC);
      cyc("badf7_exec", ev(0,0,0,0,0, 2,0,0,0,0, 0,0,0,0,0));
      cyc("badf7_halt", V_HALT);
      check("badf7_instret", 32'(instret), 32'd0);

      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      // reset during a stalled read drops mem_re immediately
      instr = 32'h0040A283;
      cyc("mid_fetch", V_FETCH);
      cyc("mid_decode", V_DEC);
      cyc("mid_adr", V_LWADR);
      mem_ready = 1'b0;
      cyc("mid_rd_wait", V_LWRD);
      rst = 1'b1;
      #1;
      check("mid_rst_ctl", 32'(obs), 32'(V_IDLE));
      @(posedge clk); #1;
      rst = 1'b0;
      mem_ready = 1'b1;
      cyc("mid_refetch", V_FETCH);
      check("mid_instret", 32'(instret), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
